// File: rtl/data_mem_split_if.sv
// Request/response bus between the core MEM stage and the split-capable data memory.
// The master drives requests; the slave answers with a registered response.
interface data_mem_split_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [2:0]            req_funct3;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_wdata;
   logic                  rsp_valid;
   logic [31:0]           rsp_rdata;
   logic                  rsp_fault;
   logic                  rsp_split;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_split
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_split
   );
endinterface

// File: rtl/data_mem_split.sv
// RV32 word-organised data memory with byte/half/word access, transparent two-word
// splitting of misaligned accesses and fault reporting on a registered response port.
module data_mem_split #(
   parameter int ADDR_WIDTH     = 32,
   parameter int MEM_SIZE       = 256,
   parameter int MISALIGN_SPLIT = 1
) (
   input logic             clk,
   input logic             rst_n,
   data_mem_split_if.slave bus
);
   localparam int IDX_W = $clog2(MEM_SIZE);

   typedef enum logic {IDLE, SPLIT2} state_t;

   state_t           state;
   logic [31:0]      mem [MEM_SIZE];
   logic [IDX_W-1:0] w0, w1, w1_q, wr_idx;
   logic [1:0]       off, off_q;
   logic [2:0]       f3_q;
   logic             we_q;
   logic [31:0]      wd_hi_q, hold_q, wr_data;
   logic [3:0]       be_hi_q, wr_be, mask;
   logic [7:0]       be8;
   logic [63:0]      wd64;
   logic             accept, illegal, misal, fault, split, wr_en;
   logic             unused_addr;

   generate
      if (ADDR_WIDTH > IDX_W + 2) begin : g_hi
         assign unused_addr = ^bus.req_addr[ADDR_WIDTH-1:IDX_W+2];
      end else begin : g_nohi
         assign unused_addr = 1'b0;
      end
   endgenerate

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
      case (f3)
         3'b000:  extend = {{24{raw[7]}}, raw[7:0]};
         3'b001:  extend = {{16{raw[15]}}, raw[15:0]};
         3'b100:  extend = {24'b0, raw[7:0]};
         3'b101:  extend = {16'b0, raw[15:0]};
         default: extend = raw;
      endcase
   endfunction

   assign bus.req_ready = (state == IDLE);

   always_comb begin
      off    = bus.req_addr[1:0];
      w0     = bus.req_addr[IDX_W+1:2];
      w1     = w0 + IDX_W'(1);
      accept = bus.req_valid && (state == IDLE);
      case (bus.req_funct3[1:0])
         2'b00:   mask = 4'b0001;
         2'b01:   mask = 4'b0011;
         2'b10:   mask = 4'b1111;
         default: mask = 4'b0000;
      endcase
      if (bus.req_we) illegal = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
      else            illegal = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3 == 3'b110);
      misal = ((bus.req_funct3[1:0] == 2'b01) && (off == 2'd3)) ||
              ((bus.req_funct3[1:0] == 2'b10) && (off != 2'd0));
      fault = illegal || (misal && (MISALIGN_SPLIT == 0));
      split = !illegal && misal && (MISALIGN_SPLIT != 0);
      // Byte lanes 0..3 land in word w, lanes 4..7 spill into word w+1.
      be8   = {4'b0, mask} << off;
      wd64  = {32'b0, bus.req_wdata} << {off, 3'b000};

      wr_en   = 1'b0;
      wr_idx  = w0;
      wr_data = wd64[31:0];
      wr_be   = be8[3:0];
      if (state == SPLIT2) begin
         wr_en   = we_q;
         wr_idx  = w1_q;
         wr_data = wd_hi_q;
         wr_be   = be_hi_q;
      end else if (accept && bus.req_we && !fault) begin
         wr_en = 1'b1;
      end
      wr_en = wr_en && rst_n;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_fault <= 1'b0;
         bus.rsp_split <= 1'b0;
         hold_q        <= '0;
         wd_hi_q       <= '0;
         be_hi_q       <= '0;
         w1_q          <= '0;
         off_q         <= '0;
         f3_q          <= '0;
         we_q          <= 1'b0;
      end else begin
         bus.rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (split) begin
                     state   <= SPLIT2;
                     hold_q  <= mem[w0];
                     wd_hi_q <= wd64[63:32];
                     be_hi_q <= be8[7:4];
                     w1_q    <= w1;
                     off_q   <= off;
                     f3_q    <= bus.req_funct3;
                     we_q    <= bus.req_we;
                  end else begin
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_fault <= fault;
                     bus.rsp_split <= 1'b0;
                     bus.rsp_rdata <= (fault || bus.req_we) ? '0 :
                                      extend(bus.req_funct3, mem[w0] >> {off, 3'b000});
                  end
               end
            end
            SPLIT2: begin
               state         <= IDLE;
               bus.rsp_valid <= 1'b1;
               bus.rsp_fault <= 1'b0;
               bus.rsp_split <= 1'b1;
               bus.rsp_rdata <= we_q ? '0 :
                                extend(f3_q, 32'({mem[w1_q], hold_q} >> {off_q, 3'b000}));
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
